// File: rtl/lcplc_pkg.sv
// Shared types and helpers for the LCPLC predictor datapath: the output register
// state encoding and the block-mean accumulator sizing/rounding helpers.
package lcplc_pkg;

   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_t;

   // Accumulator holds up to 2^block_size_log full-scale samples without overflow.
   function automatic int unsigned acc_width(input int unsigned data_width,
                                             input int unsigned block_size_log);
      return data_width + block_size_log;
   endfunction

   // Half an LSB of the mean, added before the shift to round to nearest.
   function automatic int unsigned round_const(input int unsigned block_size_log);
      return 32'd1 << (block_size_log - 1);
   endfunction

endpackage

// File: rtl/axis_output_register.sv
// One-entry valid/ready holding register; a load while the held entry is being
// handshaken replaces it in the same cycle.
module axis_output_register
   import lcplc_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  output_ready,
   output logic                  output_valid,
   output logic [DATA_WIDTH-1:0] output_data,
   output out_state_t            state
);

   out_state_t state_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= OUT_EMPTY;
         output_data <= '0;
      end else begin
         state <= state_next;
         if (load) begin
            output_data <= load_data;
         end
      end
   end

   always_comb begin
      state_next   = state;
      output_valid = 1'b0;
      case (state)
         OUT_EMPTY: begin
            if (load) begin
               state_next = OUT_FULL;
            end
         end
         OUT_FULL: begin
            output_valid = 1'b1;
            if (output_ready && !load) begin
               state_next = OUT_EMPTY;
            end
         end
         default: state_next = OUT_EMPTY;
      endcase
   end

endmodule

// File: rtl/block_mean_calculator.sv
// Streams unsigned samples, sums each block of 2^BLOCK_SIZE_LOG of them and emits
// the rounded block mean through a one-entry output register.
module block_mean_calculator
   import lcplc_pkg::*;
#(
   parameter int DATA_WIDTH     = 16,
   parameter int BLOCK_SIZE_LOG = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  input_valid,
   output logic                  input_ready,
   input  logic [DATA_WIDTH-1:0] input_data,
   output logic                  output_valid,
   input  logic                  output_ready,
   output logic [DATA_WIDTH-1:0] output_data
);

   localparam int unsigned ACC_W = acc_width(DATA_WIDTH, BLOCK_SIZE_LOG);
   localparam logic [ACC_W:0] ROUND = (ACC_W + 1)'(round_const(BLOCK_SIZE_LOG));

   logic [ACC_W-1:0]          acc;
   logic [BLOCK_SIZE_LOG-1:0] count;
   logic                      last;
   logic                      accept;
   logic                      load;
   logic [ACC_W:0]            sum;
   logic [DATA_WIDTH-1:0]     mean;
   logic                      unused_sum_bits;
   out_state_t                out_state;

   assign last = (count == {BLOCK_SIZE_LOG{1'b1}});

   // Only the closing sample of a block stalls, and only while the previous mean
   // is still pending with no handshake this cycle.
   assign input_ready = !rst && !(output_valid && !output_ready && last);
   assign accept      = input_valid && input_ready;
   assign load        = accept && last;

   assign sum  = {1'b0, acc} + {{(BLOCK_SIZE_LOG + 1){1'b0}}, input_data} + ROUND;
   assign mean = sum[BLOCK_SIZE_LOG +: DATA_WIDTH];

   // The extra sum bit never reaches the mean: the largest rounded total stays
   // below 2^ACC_W, so the all-ones block still maps to the all-ones mean.
   assign unused_sum_bits = ^{sum[ACC_W], sum[BLOCK_SIZE_LOG-1:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         acc   <= '0;
         count <= '0;
      end else if (accept) begin
         count <= count + 1'b1;
         if (last) begin
            acc <= '0;
         end else begin
            acc <= acc + {{BLOCK_SIZE_LOG{1'b0}}, input_data};
         end
      end
   end

   axis_output_register #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_out_reg (
      .clk         (clk),
      .rst         (rst),
      .load        (load),
      .load_data   (mean),
      .output_ready(output_ready),
      .output_valid(output_valid),
      .output_data (output_data),
      .state       (out_state)
   );

endmodule

// File: tb/tb_block_mean_calculator.sv
// Bench for block_mean_calculator: directed block scenarios plus random traffic,
// checked every cycle against a queue-based block-mean model.
module tb_block_mean_calculator;

   localparam int DW    = 16;
   localparam int L     = 8;
   localparam int BLK   = 1 << L;
   localparam int LIMIT = 2000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          input_valid = 1'b0;
   logic          output_ready = 1'b0;
   logic [DW-1:0] input_data = '0;
   logic          input_ready;
   logic          output_valid;
   logic [DW-1:0] output_data;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] dut_log[$];
   int            blk_cnt = 0;
   longint        blk_sum = 0;
   logic          rst_d = 1'b1;
   logic          rnd_on = 1'b0;

   always #5 clk = ~clk;

   block_mean_calculator #(
      .DATA_WIDTH    (DW),
      .BLOCK_SIZE_LOG(L)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .input_valid (input_valid),
      .input_ready (input_ready),
      .input_data  (input_data),
      .output_valid(output_valid),
      .output_ready(output_ready),
      .output_data (output_data)
   );

   function automatic logic [DW-1:0] block_mean(input longint s);
      return DW'((s + BLK / 2) / BLK);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: decides at each negedge what the coming posedge does.
   always @(negedge clk) begin : monitor
      bit er, hs, acc;
      if (rst) begin
         check("rst_ready", 32'(input_ready), 32'd0);
         if (rst_d) begin
            check("rst_valid", 32'(output_valid), 32'd0);
            check("rst_data", 32'(output_data), 32'd0);
         end
         exp_q.delete();
         blk_cnt = 0;
         blk_sum = 0;
      end else begin
         er  = !(exp_q.size() != 0 && !output_ready && blk_cnt == BLK - 1);
         hs  = exp_q.size() != 0 && output_ready;
         acc = input_valid && er;
         check("ready", 32'(input_ready), 32'(er));
         check("valid", 32'(output_valid), 32'(exp_q.size() != 0));
         if (exp_q.size() != 0) check("data", 32'(output_data), 32'(exp_q[0]));
         if (hs) begin
            dut_log.push_back(output_data);
            void'(exp_q.pop_front());
         end
         if (acc) begin
            blk_sum += longint'(input_data);
            blk_cnt++;
            if (blk_cnt == BLK) begin
               exp_q.push_back(block_mean(blk_sum));
               blk_sum = 0;
               blk_cnt = 0;
            end
         end
      end
      rst_d = rst;
   end

   task automatic idle(input int n);
      input_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      input_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic send(input logic [DW-1:0] d);
      int waited = 0;
      input_valid = 1'b1;
      input_data  = d;
      @(negedge clk);
      while (!input_ready && waited < LIMIT) begin
         waited++;
         @(negedge clk);
      end
      if (!input_ready) check("send_timeout", 32'(input_ready), 32'd1);
      @(posedge clk);
      #1;
      input_valid = 1'b0;
   endtask

   task automatic send_const(input int n, input logic [DW-1:0] d);
      for (int i = 0; i < n; i++) send(d);
   endtask

   initial begin
      do_reset();
      @(negedge clk);
      check("post_rst_ready", 32'(input_ready), 32'd1);
      check("post_rst_valid", 32'(output_valid), 32'd0);
      @(posedge clk);
      #1;

      // constant block
      output_ready = 1'b1;
      dut_log.delete();
      send_const(BLK, DW'(1000));
      check("const_latency_valid", 32'(output_valid), 32'd1);
      check("const_latency_data", 32'(output_data), 32'd1000);
      idle(3);
      check("const_count", 32'(dut_log.size()), 32'd1);
      check("const_mean", 32'(dut_log[0]), 32'd1000);

      // rounding ramps
      dut_log.delete();
      for (int i = 0; i < BLK; i++) send(DW'(i));
      for (int i = 0; i < BLK - 1; i++) send(DW'(i));
      send(DW'(0));
      idle(3);
      check("ramp_count", 32'(dut_log.size()), 32'd2);
      check("ramp_up", 32'(dut_log[0]), 32'd128);
      check("ramp_short", 32'(dut_log[1]), 32'd127);

      // full scale then zeros
      dut_log.delete();
      send_const(BLK, DW'(65535));
      send_const(BLK, DW'(0));
      idle(3);
      check("ovf_count", 32'(dut_log.size()), 32'd2);
      check("ovf_full", 32'(dut_log[0]), 32'd65535);
      check("ovf_zero", 32'(dut_log[1]), 32'd0);

      // backpressure across two blocks
      dut_log.delete();
      output_ready = 1'b0;
      fork
         begin
            send_const(BLK, DW'(5));
            send_const(BLK, DW'(9));
         end
         begin
            repeat (2 * BLK + 8) @(negedge clk);
            check("bp_stall", 32'(input_ready), 32'd0);
            check("bp_valid", 32'(output_valid), 32'd1);
            check("bp_hold", 32'(output_data), 32'd5);
            check("bp_none_out", 32'(dut_log.size()), 32'd0);
            @(posedge clk);
            #1;
            output_ready = 1'b1;
         end
      join
      idle(3);
      check("bp_count", 32'(dut_log.size()), 32'd2);
      check("bp_first", 32'(dut_log[0]), 32'd5);
      check("bp_second", 32'(dut_log[1]), 32'd9);

      // reset in the middle of a block
      dut_log.delete();
      send_const(100, DW'(500));
      do_reset();
      send_const(BLK, DW'(7));
      idle(3);
      check("rst_mid_count", 32'(dut_log.size()), 32'd1);
      check("rst_mid_mean", 32'(dut_log[0]), 32'd7);

      // handshake coinciding with the closing sample
      dut_log.delete();
      output_ready = 1'b0;
      send_const(BLK, DW'(3));
      send_const(BLK - 1, DW'(4));
      output_ready = 1'b1;
      send(DW'(4));
      @(negedge clk);
      check("sim_valid", 32'(output_valid), 32'd1);
      check("sim_data", 32'(output_data), 32'd4);
      @(posedge clk);
      #1;
      idle(3);
      check("sim_count", 32'(dut_log.size()), 32'd2);
      check("sim_first", 32'(dut_log[0]), 32'd3);

      // random traffic with random backpressure
      dut_log.delete();
      rnd_on = 1'b1;
      fork
         begin
            for (int i = 0; i < 3 * BLK; i++) begin
               if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
               send(DW'($urandom));
            end
            rnd_on = 1'b0;
         end
         begin
            while (rnd_on) begin
               @(posedge clk);
               #1;
               output_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      output_ready = 1'b1;
      idle(5);
      check("rnd_count", 32'(dut_log.size()), 32'd3);
      check("drain_valid", 32'(output_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
